// File: rtl/quadrature_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : quadrature_decoder_if
// Purpose  : Bus bundle between the encoder front end and quadrature_decoder.
//            master = sampling/control side, slave = decoder side.
// Revision : 1.0  initial release
// ============================================================================
interface quadrature_decoder_if #(
    parameter int POS_WIDTH = 16
) ();
    logic                 sample_en;
    logic                 enc_a;
    logic                 enc_b;
    logic                 clear;
    logic                 up;
    logic                 down;
    logic [POS_WIDTH-1:0] position;
    logic                 error;

    modport master (
        output sample_en, enc_a, enc_b, clear,
        input  up, down, position, error
    );

    modport slave (
        input  sample_en, enc_a, enc_b, clear,
        output up, down, position, error
    );
endinterface
`default_nettype wire

// File: rtl/quadrature_decoder.sv
`default_nettype none
// ============================================================================
// Module   : quadrature_decoder
// Purpose  : Full-resolution quadrature decoder. Synchronises the raw A/B
//            pins, optionally filters them, tracks the Gray-code state,
//            accumulates sub-steps into detents and produces up/down pulses,
//            a wrapping position count and a sticky illegal-transition flag.
// Options  : QUADRATURE_GLITCH_FILTER_EN - per-pin stability filter that only
//            accepts a pin change after FILTER_CYCLES consecutive strobes.
// Revision : 1.0  initial release
// ============================================================================
module quadrature_decoder #(
    parameter int DETENT_STEPS  = 4,
    parameter int FILTER_CYCLES = 3,
    parameter int POS_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    quadrature_decoder_if.slave  bus
);
    // Sub-step accumulator must hold +/-DETENT_STEPS transiently (max 4).
    localparam int SUB_W = 4;
    localparam logic signed [SUB_W-1:0] c_detent = SUB_W'(DETENT_STEPS);
    localparam logic signed [SUB_W-1:0] c_one    = SUB_W'(1);

    // Map {A,B} onto its position in the CW cycle 00->10->11->01.
    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        return {ab[0], ab[1] ^ ab[0]};
    endfunction

    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] cur_ab;

    // Two-flop synchronizer for both pins, runs every clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= {bus.enc_a, bus.enc_b};
            sync2_q <= sync1_q;
        end
    end

`ifdef QUADRATURE_GLITCH_FILTER_EN
    localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_filter
        logic [CNT_W-1:0] cnt_q;
        logic             acc_q;

        // Accept a new pin level only after FILTER_CYCLES consecutive strobes.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                acc_q <= 1'b0;
            end else if (bus.sample_en) begin
                if (sync2_q[gi] != acc_q) begin
                    if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
                        acc_q <= sync2_q[gi];
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_q <= '0;
                end
            end
        end

        assign cur_ab[gi] = acc_q;
    end
`else
    // Without the filter the synchronizer output is used directly on strobes.
    assign cur_ab = sync2_q;
`endif

    logic [1:0]              prev_q,   prev_d;
    logic                    primed_q, primed_d;
    logic signed [SUB_W-1:0] sub_q,    sub_d;
    logic                    up_q,     up_d;
    logic                    down_q,   down_d;
    logic                    error_q,  error_d;
    logic [POS_WIDTH-1:0]    pos_q,    pos_d;
    logic signed [SUB_W-1:0] sub_step;
    logic [1:0]              delta;
    logic                    illegal;

    // Decode the Gray-code step, accumulate into detents, apply clear.
    always_comb begin
        prev_d   = prev_q;
        primed_d = primed_q;
        sub_d    = sub_q;
        up_d     = 1'b0;
        down_d   = 1'b0;
        error_d  = error_q;
        pos_d    = pos_q;
        sub_step = sub_q;
        illegal  = 1'b0;
        delta    = gray_idx(cur_ab) - gray_idx(prev_q);

        if (bus.sample_en) begin
            prev_d = cur_ab;
            if (!primed_q) begin
                primed_d = 1'b1;
            end else begin
                case (delta)
                    2'd1:    sub_step = sub_q + c_one;
                    2'd3:    sub_step = sub_q - c_one;
                    2'd2: begin
                        illegal  = 1'b1;
                        sub_step = '0;
                    end
                    default: sub_step = sub_q;
                endcase

                if (sub_step == c_detent) begin
                    sub_d = '0;
                    up_d  = 1'b1;
                    pos_d = pos_q + POS_WIDTH'(1);
                end else if (sub_step == -c_detent) begin
                    sub_d  = '0;
                    down_d = 1'b1;
                    pos_d  = pos_q - POS_WIDTH'(1);
                end else begin
                    sub_d = sub_step;
                end
            end
        end

        // Clear overrides the count; a same-cycle illegal step keeps error set.
        if (bus.clear) begin
            pos_d   = '0;
            error_d = 1'b0;
        end
        if (illegal) begin
            error_d = 1'b1;
        end
    end

    // Decoder state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= 2'b00;
            primed_q <= 1'b0;
            sub_q    <= '0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            error_q  <= 1'b0;
            pos_q    <= '0;
        end else begin
            prev_q   <= prev_d;
            primed_q <= primed_d;
            sub_q    <= sub_d;
            up_q     <= up_d;
            down_q   <= down_d;
            error_q  <= error_d;
            pos_q    <= pos_d;
        end
    end

    assign bus.up       = up_q;
    assign bus.down     = down_q;
    assign bus.position = pos_q;
    assign bus.error    = error_q;
endmodule
`default_nettype wire
